matrix_scan_ctrl: RTL and testbench

- Row-scan sequencer for the 64x32 HUB75 LED matrix (1/16 scan, two half-panels driven together).
- Reads pixel pairs from a double-buffered framebuffer RAM and shifts each row out on R0/G0/B0/R1/G1/B1 with a shift clock.
- Latches the row and drives the D..A row address, OE blanking and per-row display time.
- Gives the game logic a frame-boundary buffer swap handshake, so frames never tear.

---
 rtl/matrix_scan_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl
// Row-scan sequencer for a 64x32 HUB75 LED matrix (1/16 scan, both
// half-panels shifted together). Each row is read pixel-pair by
// pixel-pair from a double-buffered framebuffer RAM and shifted out on
// R0/G0/B0/R1/G1/B1 with SCLK. The row is then latched and displayed
// for ON_CYCLES clocks. Front/back buffers are exchanged only at a frame
// boundary, so the game logic never sees a torn frame.
//
// Ports
//   clk, rst        system clock; asynchronous active-high reset
//   en              scanning enable, sampled only at row boundaries
//   swap_req        level from game logic: back buffer is complete
//   swap_ack        one-cycle pulse: buffers have been exchanged
//   buf_sel         current front buffer (game logic writes !buf_sel)
//   fb_rd_en        framebuffer read strobe
//   fb_addr         {buf_sel, row[3:0], col[5:0]}
//   fb_rdata        {R0,G0,B0,R1,G1,B1}, valid 1 cycle after fb_rd_en
//   A, B, C, D      row address, {D,C,B,A} = latched row
//   R0..B1          pixel data to the panel
//   SCLK            panel shift clock (panel samples on its rising edge)
//   LAT             row latch, active-high
//   OE              output blanking, 1 = panel dark
//   state_dbg       current FSM state
//
// Handshake: swap_req is a level held by the game logic until it
// observes swap_ack. The request is sampled on the clock edge that ends
// the FRAME_END cycle; buf_sel toggles and swap_ack pulses on that same
// edge, so the first read of the next frame already uses the new buffer.
//
// All outputs are registered: each output register is loaded on the edge
// that starts the cycle it describes.
module matrix_scan_ctrl #(
    parameter int COLS      = 64,
    parameter int ROWS      = 16,
    parameter int ON_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        buf_sel,
    output logic        fb_rd_en,
    output logic [10:0] fb_addr,
    input  logic [5:0]  fb_rdata,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        R0,
    output logic        G0,
    output logic        B0,
    output logic        R1,
    output logic        G1,
    output logic        B1,
    output logic        SCLK,
    output logic        LAT,
    output logic        OE,
    output logic [2:0]  state_dbg
);

    // on_cnt runs 0..ON_CYCLES-1
    localparam int OW = (ON_CYCLES < 2) ? 1 : $clog2(ON_CYCLES);

    localparam logic [6:0]    COL_LAST = 7'(COLS - 1);
    localparam logic [6:0]    COL_END  = 7'(COLS);
    localparam logic [3:0]    ROW_LAST = 4'(ROWS - 1);
    localparam logic [OW-1:0] ON_LAST  = OW'(ON_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT     = 3'd1,
        LATCH     = 3'd2,
        DISPLAY   = 3'd3,
        FRAME_END = 3'd4
    } state_t;

    state_t        state;
    logic [3:0]    row;
    logic [6:0]    col;
    logic          phase;
    logic [OW-1:0] on_cnt;

    logic [6:0]    col_inc;
    logic [3:0]    row_inc;
    logic          buf_next;

    assign col_inc   = col + 7'd1;
    assign row_inc   = (row == ROW_LAST) ? 4'd0 : row + 4'd1;
    assign buf_next  = buf_sel ^ swap_req;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            row      <= 4'd0;
            col      <= 7'd0;
            phase    <= 1'b0;
            on_cnt   <= '0;
            buf_sel  <= 1'b0;
            swap_ack <= 1'b0;
            fb_rd_en <= 1'b0;
            fb_addr  <= 11'd0;
            {D, C, B, A} <= 4'd0;
            {R0, G0, B0, R1, G1, B1} <= 6'd0;
            SCLK     <= 1'b0;
            LAT      <= 1'b0;
            OE       <= 1'b1;
        end else begin
            swap_ack <= 1'b0;
            case (state)
                IDLE: begin
                    OE <= 1'b1;
                    if (en) begin
                        state    <= SHIFT;
                        col      <= 7'd0;
                        phase    <= 1'b0;
                        fb_rd_en <= 1'b1;
                        fb_addr  <= {buf_sel, row, 6'd0};
                        SCLK     <= 1'b0;
                    end
                end

                SHIFT: begin
                    if (!phase) begin
                        if (col == COL_END) begin
                            // Trailing SCLK cycle for the last column is done.
                            state        <= LATCH;
                            SCLK         <= 1'b0;
                            LAT          <= 1'b1;
                            {D, C, B, A} <= row;
                        end else begin
                            phase    <= 1'b1;
                            fb_rd_en <= 1'b0;
                            SCLK     <= 1'b0;
                        end
                    end else begin
                        // RAM data for column col is valid now; present it
                        // while SCLK is high in the following cycle.
                        {R0, G0, B0, R1, G1, B1} <= fb_rdata;
                        phase <= 1'b0;
                        col   <= col_inc;
                        SCLK  <= 1'b1;
                        if (col == COL_LAST) begin
                            fb_rd_en <= 1'b0;
                        end else begin
                            fb_rd_en <= 1'b1;
                            fb_addr  <= {buf_sel, row, col_inc[5:0]};
                        end
                    end
                end

                LATCH: begin
                    state  <= DISPLAY;
                    LAT    <= 1'b0;
                    OE     <= 1'b0;
                    on_cnt <= '0;
                end

                DISPLAY: begin
                    if (on_cnt == ON_LAST) begin
                        OE  <= 1'b1;
                        row <= row_inc;
                        if (row == ROW_LAST) begin
                            state <= FRAME_END;
                        end else if (en) begin
                            state    <= SHIFT;
                            col      <= 7'd0;
                            phase    <= 1'b0;
                            fb_rd_en <= 1'b1;
                            fb_addr  <= {buf_sel, row_inc, 6'd0};
                            SCLK     <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        on_cnt <= on_cnt + OW'(1);
                    end
                end

                FRAME_END: begin
                    OE <= 1'b1;
                    if (swap_req) begin
                        buf_sel  <= ~buf_sel;
                        swap_ack <= 1'b1;
                    end
                    if (en) begin
                        state    <= SHIFT;
                        col      <= 7'd0;
                        phase    <= 1'b0;
                        fb_rd_en <= 1'b1;
                        fb_addr  <= {buf_next, row, 6'd0};
                        SCLK     <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    OE    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// tb_matrix_scan_ctrl
// Randomized framebuffer contents with a row-level reference model: each
// planned row pushes its expected reads, shifted pixels, latched row,
// display length and any buffer swap into queues; a negedge monitor pops
// and compares whenever the panel interface shows an event.
module tb_matrix_scan_ctrl;

    localparam int COLS       = 64;
    localparam int ROWS       = 16;
    localparam int ON_CYCLES  = 256;
    localparam int ROW_CYCLES = 2 * COLS + 2 + ON_CYCLES;
    localparam int FRAME      = ROWS * ROW_CYCLES + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        swap_req;
    logic        swap_ack;
    logic        buf_sel;
    logic        fb_rd_en;
    logic [10:0] fb_addr;
    logic [5:0]  fb_rdata = 6'd0;
    logic        A, B, C, D;
    logic        R0, G0, B0, R1, G1, B1;
    logic        SCLK, LAT, OE;
    logic [2:0]  state_dbg;

    wire  [5:0]  pix  = {R0, G0, B0, R1, G1, B1};
    wire  [3:0]  abcd = {D, C, B, A};

    matrix_scan_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .ON_CYCLES(ON_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .swap_req(swap_req), .swap_ack(swap_ack), .buf_sel(buf_sel),
        .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
        .A(A), .B(B), .C(C), .D(D),
        .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
        .SCLK(SCLK), .LAT(LAT), .OE(OE), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Framebuffer RAM model: one-cycle read latency.
    logic [5:0] mem [0:2047];
    always @(posedge clk) if (fb_rd_en) fb_rdata <= mem[fb_addr];

    // ---------------- scoreboard ----------------
    logic [10:0] exp_addr_q[$];
    logic [5:0]  exp_pix_q[$];
    logic [3:0]  exp_lat_q[$];
    int          exp_on_q[$];
    logic        exp_ack_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @cyc %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h expected=%0h @cyc %0d", name, act, exp, cyc);
    endtask

    // Reference model: row-level view of the scan.
    int   m_row = 0;
    logic m_buf = 1'b0;

    task automatic push_row(input bit swap_at_frame_end);
        logic [10:0] a;
        for (int c = 0; c < COLS; c++) begin
            a = {m_buf, 4'(m_row), 6'(c)};
            exp_addr_q.push_back(a);
            exp_pix_q.push_back(mem[a]);
        end
        exp_lat_q.push_back(4'(m_row));
        exp_on_q.push_back(ON_CYCLES);
        m_row = (m_row + 1) % ROWS;
        if (m_row == 0 && swap_at_frame_end) begin
            m_buf = ~m_buf;
            exp_ack_q.push_back(m_buf);
        end
    endtask

    // ---------------- monitor ----------------
    logic       prev_sclk = 1'b0;
    logic       prev_ack  = 1'b0;
    logic       prev_buf  = 1'b0;
    logic [3:0] prev_abcd = 4'd0;
    int         low_cnt   = 0;
    int         lat_count = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_sclk = 1'b0;
            prev_ack  = 1'b0;
            prev_buf  = buf_sel;
            prev_abcd = abcd;
            low_cnt   = 0;
        end else begin
            if (fb_rd_en) begin
                if (exp_addr_q.size() == 0) fail_evt("unexpected_read", fb_addr, 0);
                else check("fb_addr", fb_addr, exp_addr_q.pop_front());
            end
            if (SCLK && !prev_sclk) begin
                if (exp_pix_q.size() == 0) fail_evt("unexpected_sclk", pix, 0);
                else check("pixel", pix, exp_pix_q.pop_front());
            end
            if (LAT) begin
                lat_count++;
                check("oe_at_latch", OE, 1);
                if (exp_lat_q.size() == 0) fail_evt("unexpected_latch", abcd, 0);
                else check("latched_row", abcd, exp_lat_q.pop_front());
            end
            if (!OE) begin
                low_cnt++;
            end else if (low_cnt > 0) begin
                if (exp_on_q.size() == 0) fail_evt("unexpected_display", low_cnt, 0);
                else check("display_len", low_cnt, exp_on_q.pop_front());
                low_cnt = 0;
            end
            if (abcd != prev_abcd) check("row_change_in_latch", LAT, 1);
            if (buf_sel != prev_buf) check("buf_change_with_ack", swap_ack, 1);
            if (swap_ack) begin
                if (prev_ack) fail_evt("ack_width", 2, 1);
                if (exp_ack_q.size() == 0) fail_evt("unexpected_ack", buf_sel, 0);
                else check("buf_after_ack", buf_sel, exp_ack_q.pop_front());
            end
            prev_sclk = SCLK;
            prev_ack  = swap_ack;
            prev_buf  = buf_sel;
            prev_abcd = abcd;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_lat(input int n, input int budget, input string name);
        int k = 0;
        while (lat_count < n && k < budget) begin tick(); k++; end
        if (lat_count < n) fail_evt(name, lat_count, n);
    endtask

    task automatic wait_read(input int budget, input string name);
        int k = 0;
        while (!fb_rd_en && k < budget) begin tick(); k++; end
        if (!fb_rd_en) fail_evt(name, 0, 1);
    endtask

    task automatic wait_ack(input int budget, input string name);
        int k = 0;
        while (!swap_ack && k < budget) begin tick(); k++; end
        if (!swap_ack) fail_evt(name, 0, 1);
    endtask

    task automatic wait_display_end(input int budget, input string name);
        int k = 0;
        while (OE && k < budget) begin tick(); k++; end
        while (!OE && k < budget) begin tick(); k++; end
        if (!OE || k >= budget) fail_evt(name, k, budget);
    endtask

    function automatic int pending();
        return exp_addr_q.size() + exp_pix_q.size() + exp_lat_q.size()
             + exp_on_q.size() + exp_ack_q.size();
    endfunction

    // ---------------- stimulus ----------------
    int s0, t_row0;

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 6'($urandom_range(0, 63));
        for (int c = 0; c < COLS; c++) mem[c] = 6'(c);   // buffer 0 row 0: pixel = column

        rst = 1'b1; en = 1'b0; swap_req = 1'b0;
        repeat (3) tick();
        check("rst_oe", OE, 1);
        check("rst_lat", LAT, 0);
        check("rst_sclk", SCLK, 0);
        check("rst_rd_en", fb_rd_en, 0);
        check("rst_ack", swap_ack, 0);
        check("rst_buf", buf_sel, 0);
        check("rst_row", abcd, 0);
        check("rst_rgb", pix, 0);
        rst = 1'b0;

        repeat (4) tick();
        check("idle_oe", OE, 1);
        check("idle_no_read", fb_rd_en, 0);

        // Plan: frame 0 with a swap, frame 1 without, then rows 0..3.
        for (int r = 0; r < ROWS; r++) push_row(1'b1);
        for (int r = 0; r < ROWS; r++) push_row(1'b0);
        for (int r = 0; r < 4; r++)    push_row(1'b0);

        en = 1'b1;
        s0 = cyc;
        wait_read(20, "first_read_timeout");
        check("first_read_latency", cyc - s0, 1);
        s0 = cyc;
        wait_lat(1, 300, "first_latch_timeout");
        check("latch_offset", cyc - s0, 2 * COLS + 1);
        t_row0 = cyc;

        wait_lat(6, 3000, "row5_latch_timeout");
        swap_req = 1'b1;
        check("no_early_swap", buf_sel, 0);
        wait_ack(7000, "swap_ack_timeout");
        swap_req = 1'b0;

        wait_lat(17, 1000, "frame1_latch_timeout");
        check("frame_period", cyc - t_row0, FRAME);
        check("buf_after_frame0", buf_sel, 1);

        // Drop en during the SHIFT of row 3 of the third frame.
        wait_lat(35, 7000, "row2_latch_timeout");
        wait_read(400, "row3_read_timeout");
        repeat (10) tick();
        en = 1'b0;
        wait_lat(36, 400, "row3_latch_timeout");
        wait_display_end(400, "row3_display_timeout");
        repeat (30) tick();
        check("stop_oe", OE, 1);
        check("stop_no_read", fb_rd_en, 0);
        check("stop_row", abcd, 3);
        check("stop_buf", buf_sel, 1);
        check("stop_drained", pending(), 0);

        // Resume at row 4, then reset in the middle of row 5's display.
        push_row(1'b0);
        push_row(1'b0);
        en = 1'b1;
        s0 = cyc;
        wait_read(20, "resume_read_timeout");
        check("resume_latency", cyc - s0, 1);
        wait_lat(38, 1200, "row5_latch2_timeout");
        repeat (100) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_oe", OE, 1);
        check("arst_lat", LAT, 0);
        check("arst_sclk", SCLK, 0);
        check("arst_rgb", pix, 0);
        check("arst_row", abcd, 0);
        check("arst_buf", buf_sel, 0);
        check("arst_pending_display", exp_on_q.size(), 1);
        check("arst_pending_other", exp_addr_q.size() + exp_pix_q.size() + exp_lat_q.size(), 0);
        exp_addr_q.delete();
        exp_pix_q.delete();
        exp_lat_q.delete();
        exp_on_q.delete();
        exp_ack_q.delete();
        m_row = 0;
        m_buf = 1'b0;

        repeat (2) tick();
        push_row(1'b0);
        rst = 1'b0;
        s0 = cyc;
        wait_read(20, "post_rst_read_timeout");
        check("post_rst_latency", cyc - s0, 1);
        check("post_rst_addr", fb_addr, 11'h000);
        wait_lat(39, 300, "post_rst_latch_timeout");
        en = 1'b0;
        wait_display_end(400, "post_rst_display_timeout");
        repeat (20) tick();
        check("final_drained", pending(), 0);
        check("final_oe", OE, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
